// File: rtl/seller_pkg.sv
// Shared types and constants for the coin-operated drink seller controller.
// Money values are in units of 0.5 yuan.
package seller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam logic [2:0] COIN_D1 = 3'd1;
    localparam logic [2:0] COIN_D2 = 3'd2;
    localparam logic [2:0] COIN_D3 = 3'd4;

    typedef enum logic [1:0] {
        CHG_NONE = 2'b00,
        CHG_HALF = 2'b01,
        CHG_ONE  = 2'b10
    } chg_t;

endpackage

// File: rtl/seller_coin_dec.sv
// Coin pulse decoder: exactly one active pulse is a valid coin.
// Any multi-hot combination is flagged as illegal.
module seller_coin_dec
    import seller_pkg::*;
(
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    output logic       coin_vld,
    output logic       coin_illegal,
    output logic [2:0] coin_val
);

    always_comb begin
        coin_vld     = 1'b0;
        coin_illegal = 1'b0;
        coin_val     = 3'd0;
        case ({d3, d2, d1})
            3'b000: ;
            3'b001: begin coin_vld = 1'b1; coin_val = COIN_D1; end
            3'b010: begin coin_vld = 1'b1; coin_val = COIN_D2; end
            3'b100: begin coin_vld = 1'b1; coin_val = COIN_D3; end
            default: coin_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seller_ctrl.sv
// Drink seller sequencing controller: credit accumulation, product vend and
// coin-by-coin change payout through req/ack handshakes.
module seller_ctrl
    import seller_pkg::*;
#(
    parameter int PRICE_A    = 3,
    parameter int PRICE_B    = 5,
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                d1,
    input  logic                d2,
    input  logic                d3,
    input  logic                sel,
    input  logic                cancel,
    output logic                vend_req,
    input  logic                vend_ack,
    output logic [1:0]          chg_coin,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_rej
);

    typedef logic [CREDIT_W-1:0] credit_t;
    typedef logic [CREDIT_W:0]   sum_t;

    localparam credit_t PRICE_A_C = credit_t'(PRICE_A);
    localparam credit_t PRICE_B_C = credit_t'(PRICE_B);
    localparam sum_t    MAX_C     = sum_t'(MAX_CREDIT);
    localparam credit_t ONE_C     = credit_t'(1);
    localparam credit_t TWO_C     = credit_t'(2);

    state_t  state_q, state_d;
    credit_t credit_q, credit_d;
    logic    prod_q, prod_d;
    logic    coin_rej_q, coin_rej_d;

    logic       coin_vld;
    logic       coin_illegal;
    logic [2:0] coin_val;
    sum_t       coin_sum;
    logic       fits;
    logic       accept;
    credit_t    price;
    credit_t    chg_step;

    seller_coin_dec u_coin_dec (
        .d1          (d1),
        .d2          (d2),
        .d3          (d3),
        .coin_vld    (coin_vld),
        .coin_illegal(coin_illegal),
        .coin_val    (coin_val)
    );

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        prod_d     = prod_q;
        accept     = 1'b0;
        coin_sum   = sum_t'(credit_q) + sum_t'(coin_val);
        fits       = coin_vld && (coin_sum <= MAX_C);
        price      = prod_q ? PRICE_B_C : PRICE_A_C;
        chg_step   = (credit_q >= TWO_C) ? TWO_C : ONE_C;

        case (state_q)
            IDLE: begin
                if (fits) begin
                    accept   = 1'b1;
                    credit_d = credit_t'(coin_val);
                    prod_d   = sel;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                // Cancel takes priority and refuses any coin in the same cycle.
                if (cancel) begin
                    state_d = CHANGE;
                end else begin
                    if (fits) begin
                        accept   = 1'b1;
                        credit_d = coin_sum[CREDIT_W-1:0];
                    end
                    if (credit_q >= price) begin
                        state_d = VEND;
                    end
                end
            end
            VEND: begin
                if (vend_ack) begin
                    credit_d = credit_q - price;
                    state_d  = (credit_q == price) ? IDLE : CHANGE;
                end
            end
            CHANGE: begin
                if (chg_ack) begin
                    credit_d = credit_q - chg_step;
                    if (credit_q == chg_step) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase

        // Any presented pulse pattern that was not taken goes back to the customer.
        coin_rej_d = (coin_vld || coin_illegal) && !accept;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            prod_q     <= 1'b0;
            coin_rej_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            prod_q     <= prod_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    assign vend_req = (state_q == VEND);
    assign busy     = (state_q != IDLE);
    assign credit   = credit_q;
    assign coin_rej = coin_rej_q;
    assign chg_coin = (state_q != CHANGE) ? CHG_NONE
                    : (credit_q >= TWO_C) ? CHG_ONE : CHG_HALF;

endmodule

// File: tb/tb_seller_ctrl.sv
// Bench for seller_ctrl: directed scenarios with literal expectations, then
// randomized coins, selects, cancels and handshakes against a behavioural model.
module tb_seller_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       d1, d2, d3, sel, cancel, vend_ack, chg_ack;
    logic       vend_req;
    logic [1:0] chg_coin;
    logic [3:0] credit;
    logic       busy, coin_rej;

    int n_chk = 0;
    int n_err = 0;

    // Model: phase 0 waiting, 1 collecting, 2 vending, 3 paying change.
    int m_phase;
    int m_credit;
    int m_price;
    int m_rej;

    seller_ctrl #(
        .PRICE_A   (3),
        .PRICE_B   (5),
        .CREDIT_W  (4),
        .MAX_CREDIT(15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .sel     (sel),
        .cancel  (cancel),
        .vend_req(vend_req),
        .vend_ack(vend_ack),
        .chg_coin(chg_coin),
        .chg_ack (chg_ack),
        .credit  (credit),
        .busy    (busy),
        .coin_rej(coin_rej)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_credit = 0;
        m_price  = 3;
        m_rej    = 0;
    endtask

    task automatic model_step(input bit a1, input bit a2, input bit a3, input bit s,
                              input bit c, input bit va, input bit ca);
        int  ncoins;
        int  val;
        bit  valid;
        bit  taken;
        bit  ready;
        ncoins = int'(a1) + int'(a2) + int'(a3);
        val    = a1 ? 1 : (a2 ? 2 : 4);
        valid  = (ncoins == 1);
        taken  = 1'b0;
        case (m_phase)
            0: if (valid && val <= 15) begin
                taken    = 1'b1;
                m_credit = val;
                m_price  = s ? 5 : 3;
                m_phase  = 1;
            end
            1: if (c) begin
                m_phase = 3;
            end else begin
                ready = (m_credit >= m_price);
                if (valid && m_credit + val <= 15) begin
                    taken    = 1'b1;
                    m_credit = m_credit + val;
                end
                if (ready) m_phase = 2;
            end
            2: if (va) begin
                m_credit = m_credit - m_price;
                m_phase  = (m_credit > 0) ? 3 : 0;
            end
            default: if (ca) begin
                m_credit = m_credit - ((m_credit >= 2) ? 2 : 1);
                if (m_credit == 0) m_phase = 0;
            end
        endcase
        m_rej = (ncoins > 0 && !taken) ? 1 : 0;
    endtask

    task automatic compare_model();
        chk("credit",   32'(credit),   32'(m_credit));
        chk("busy",     32'(busy),     32'(m_phase != 0));
        chk("vend_req", 32'(vend_req), 32'(m_phase == 2));
        chk("chg_coin", 32'(chg_coin), (m_phase == 3) ? ((m_credit >= 2) ? 32'd2 : 32'd1) : 32'd0);
        chk("coin_rej", 32'(coin_rej), 32'(m_rej));
    endtask

    task automatic cyc(input bit a1, input bit a2, input bit a3, input bit s,
                       input bit c, input bit va, input bit ca);
        d1 = a1; d2 = a2; d3 = a3; sel = s; cancel = c; vend_ack = va; chg_ack = ca;
        @(posedge clk);
        #1;
        model_step(a1, a2, a3, s, c, va, ca);
        compare_model();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_credit"},   32'(credit),   32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_vend_req"}, 32'(vend_req), 32'd0);
        chk({tag, "_chg_coin"}, 32'(chg_coin), 32'd0);
        chk({tag, "_coin_rej"}, 32'(coin_rej), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        d1 = 0; d2 = 0; d3 = 0; sel = 0; cancel = 0; vend_ack = 0; chg_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all_zero("reset");
        rst = 1'b1;

        // Product A paid exactly with three half-yuan coins.
        cyc(1,0,0, 0,0,0,0); chk("t1_credit1", 32'(credit), 32'd1);
        cyc(1,0,0, 0,0,0,0); chk("t1_credit2", 32'(credit), 32'd2);
        cyc(1,0,0, 0,0,0,0); chk("t1_credit3", 32'(credit), 32'd3);
        chk("t1_no_vend_yet", 32'(vend_req), 32'd0);
        cyc(0,0,0, 0,0,0,0); chk("t1_vend_req", 32'(vend_req), 32'd1);
        cyc(0,0,0, 0,0,1,0); chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_no_change", 32'(chg_coin), 32'd0);

        // Overpay product A: one 1-yuan change coin.
        cyc(0,0,1, 0,0,0,0); chk("t2_credit4", 32'(credit), 32'd4);
        cyc(1,0,0, 0,0,0,0); chk("t2_credit5", 32'(credit), 32'd5);
        chk("t2_vend_req", 32'(vend_req), 32'd1);
        cyc(0,0,0, 0,0,1,0); chk("t2_rem", 32'(credit), 32'd2);
        chk("t2_chg_one", 32'(chg_coin), 32'd2);
        cyc(0,0,0, 0,0,0,1); chk("t2_done_credit", 32'(credit), 32'd0);
        chk("t2_done_busy", 32'(busy), 32'd0);

        // Product B with sel toggling mid-sequence; half-yuan change.
        cyc(0,1,0, 1,0,0,0);
        cyc(0,1,0, 0,0,0,0);
        cyc(0,1,0, 1,0,0,0); chk("t3_credit6", 32'(credit), 32'd6);
        cyc(0,0,0, 0,0,0,0); chk("t3_vend_req", 32'(vend_req), 32'd1);
        cyc(0,0,0, 0,0,1,0); chk("t3_rem", 32'(credit), 32'd1);
        chk("t3_chg_half", 32'(chg_coin), 32'd1);
        cyc(0,0,0, 0,0,0,1); chk("t3_idle", 32'(busy), 32'd0);

        // Cancel beats a simultaneous coin; full refund.
        cyc(0,1,0, 0,0,0,0);
        cyc(1,0,0, 0,1,0,0); chk("t4_rej", 32'(coin_rej), 32'd1);
        chk("t4_credit", 32'(credit), 32'd2);
        chk("t4_chg_one", 32'(chg_coin), 32'd2);
        chk("t4_no_vend", 32'(vend_req), 32'd0);
        cyc(0,0,0, 0,0,0,1); chk("t4_idle", 32'(busy), 32'd0);

        // Multi-hot coin in IDLE, coin during VEND, then reset mid-vend.
        cyc(1,0,1, 0,0,0,0); chk("t5_multi_rej", 32'(coin_rej), 32'd1);
        chk("t5_multi_idle", 32'(busy), 32'd0);
        cyc(1,0,0, 0,0,0,0);
        cyc(1,0,0, 0,0,0,0);
        cyc(1,0,0, 0,0,0,0);
        cyc(0,0,0, 0,0,0,0);
        cyc(0,1,0, 0,0,0,0); chk("t5_vend_rej", 32'(coin_rej), 32'd1);
        chk("t5_vend_credit", 32'(credit), 32'd3);
        chk("t5_vend_held", 32'(vend_req), 32'd1);
        d2 = 0;
        rst = 1'b0;
        #1;
        model_reset();
        check_all_zero("t5_async_rst");
        rst = 1'b1;
        cyc(1,0,0, 0,0,0,0); chk("t5_after_rst", 32'(credit), 32'd1);
        cyc(0,0,0, 0,1,0,0);
        for (int k = 0; k < 4; k++) cyc(0,0,0, 0,0,0,1);

        // Randomized traffic including spurious acks and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 250) begin
                rst = 1'b0;
                #1;
                model_reset();
                compare_model();
                rst = 1'b1;
            end
            cyc(($urandom % 6) == 0, ($urandom % 6) == 0, ($urandom % 6) == 0,
                1'($urandom), ($urandom % 16) == 0,
                ($urandom % 4) == 0, ($urandom % 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
